detect_event_counter: RTL and testbench
=======================================

Name: detect_event_counter

Overview:
Downstream consumer of the sequence-detector stage. Counts rising edges on its two detection outputs, Z1 and Z2, in two independent 2-digit BCD counters. Drives a 4-digit multiplexed 7-segment display showing both counts, and exposes the counts and sticky overflow flags for the board top level.

Parameters:
REFRESH_DIV, 50000, clock cycles each display digit is held before advancing (minimum 2).
SEG_ACTIVE_LOW, 1, 1 = seg outputs active-low (common-anode); 0 = active-high.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
z1  input  1  Z1 level from the sequence detector.
z2  input  1  Z2 level from the sequence detector.
clr  input  1  synchronous clear of both counters and overflow flags; display scan is unaffected.
cnt1  output  8  BCD count of z1 rising edges; [7:4] tens, [3:0] ones.
cnt2  output  8  BCD count of z2 rising edges; same layout.
ovf1  output  1  sticky flag: cnt1 wrapped 99->00.
ovf2  output  1  sticky flag: cnt2 wrapped 99->00.
seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}.
an  output  4  digit enables, active-low, one-hot-zero.

Behaviour:
- Reset applies when rst=1 at posedge. All state and outputs are registered.
- Reset values: z1_d=0, z2_d=0, cnt1=8'h00, cnt2=8'h00, ovf1=0, ovf2=0, refresh counter=0, digit index=0, an=4'b1110.
- Reset value of seg is the "0" glyph: 7'b1000000 when SEG_ACTIVE_LOW=1, 7'b0111111 when 0.
- Edge detect: z1_d/z2_d register z1/z2 every cycle. Event condition is z1=1 and z1_d=0 (likewise for z2).
- An event updates cnt on the same posedge, so the new count is visible 1 cycle after z1 is first sampled high.
- A level held high N cycles counts once.
- z1 high while rst deasserts counts once, because z1_d resets to 0.
- BCD increment:
  - ones<9: ones+1.
  - ones=9: ones=0 and tens+1.
  - tens=9 and ones=9: cnt=00 and ovf set.
  - ovf stays 1 until rst or clr.
  - Nibbles never hold values A-F.
- Simultaneous z1 and z2 events in one cycle: both counters increment independently.
- clr=1: cnt1, cnt2, ovf1, ovf2 go to 0 at that posedge.
  - clr wins over a same-cycle event; that event is lost.
  - Edge registers still update, so a level held through clr does not re-count.
- Precedence: rst > clr > increment.
- Display scan:
  - Refresh counter runs 0..REFRESH_DIV-1 continuously. At REFRESH_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0.
  - Digit mapping: idx0 = cnt1 ones, idx1 = cnt1 tens, idx2 = cnt2 ones, idx3 = cnt2 tens.
  - an[idx]=0, all other bits 1.
  - seg is registered and updated every cycle from the currently selected nibble. It reflects a count change within 1 cycle even mid-dwell.
  - an and seg change on the same posedge when the digit advances.
- Glyphs, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Non-BCD nibbles display blank (all segments off). Unreachable in normal operation.
  - SEG_ACTIVE_LOW=1 inverts all seven bits.
- rst mid-scan returns to idx0 and refresh counter 0 on the next posedge. clr does not touch the scan.

Test Plan:
- Reset: assert rst 2 cycles with z1=z2=0 -> cnt1=cnt2=8'h00, ovf1=ovf2=0, an=4'b1110, seg=7'b1000000.
- Single and held edge: z1 low->high held 5 cycles, then low -> cnt1=8'h01 exactly 1 cycle after the first high sample, with no further increments. Repeat 9 more pulses -> cnt1=8'h10.
- Wrap: 100 separated z2 pulses -> cnt2 passes 8'h99 then reads 8'h00 with ovf2=1. One more pulse -> cnt2=8'h01, ovf2 still 1. Then clr=1 -> ovf2=0, cnt2=8'h00.
- Simultaneous and precedence: z1 and z2 rise in the same cycle -> both +1. z1 rises in the same cycle as clr=1 -> cnt1=8'h00, and the held z1 is not counted afterward.
- Scan with REFRESH_DIV=4, cnt1=8'h27, cnt2=8'h05:
  - an sequence 1110,1101,1011,0111, each held 4 cycles.
  - seg (active-low) sequence: 7'b1111000 ("7"), 7'b0100100 ("2"), 7'b0010010 ("5"), 7'b1000000 ("0").
  - Then returns to idx0.
- rst mid-operation: with counts nonzero and idx=2, assert rst 1 cycle -> all reset values on the next posedge. Deassert with z1=1 -> cnt1=8'h01 one cycle later.

Source files
------------

// File: rtl/detect_event_counter.sv
// Counts rising edges of the detector's z1/z2 outputs in two 2-digit BCD counters
// and scans both counts onto a 4-digit multiplexed 7-segment display.
module detect_event_counter #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       z1,
    input  logic       z2,
    input  logic       clr,
    output logic [7:0] cnt1,
    output logic [7:0] cnt2,
    output logic       ovf1,
    output logic       ovf2,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned SEG_W    = 7;
    localparam int unsigned IDX_W    = 2;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_POL  = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [SEG_W-1:0] SEG_ZERO = 7'h3F ^ SEG_POL;

    // BCD increment; bit 8 flags the 99 -> 00 wrap.
    function automatic logic [CNT_W:0] bcd_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] r;
        if (c[3:0] != 4'd9) begin
            r = {1'b0, c[7:4], c[3:0] + 4'd1};
        end else if (c[7:4] != 4'd9) begin
            r = {1'b0, c[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b1, 8'h00};
        end
        return r;
    endfunction

    // Active-high gfedcba glyph; non-BCD values stay blank.
    function automatic logic [SEG_W-1:0] glyph(input logic [NIB_W-1:0] n);
        logic [SEG_W-1:0] g;
        case (n)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic             z1_q, z2_q;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic             ovf1_q, ovf1_d, ovf2_q, ovf2_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [CNT_W:0]   inc1, inc2;
    logic [NIB_W-1:0] nib_d;
    logic             ev1, ev2;

    assign ev1  = z1 & ~z1_q;
    assign ev2  = z2 & ~z2_q;
    assign inc1 = bcd_inc(cnt1_q);
    assign inc2 = bcd_inc(cnt2_q);

    // Counter next state: clear beats a same-cycle event.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        ovf1_d = ovf1_q;
        ovf2_d = ovf2_q;
        if (clr) begin
            cnt1_d = '0;
            cnt2_d = '0;
            ovf1_d = 1'b0;
            ovf2_d = 1'b0;
        end else begin
            if (ev1) begin
                cnt1_d = inc1[CNT_W-1:0];
                ovf1_d = ovf1_q | inc1[CNT_W];
            end
            if (ev2) begin
                cnt2_d = inc2[CNT_W-1:0];
                ovf2_d = ovf2_q | inc2[CNT_W];
            end
        end
    end

    // Scan next state; seg follows the next digit and next counts so an/seg/cnt stay coherent.
    always_comb begin
        refresh_d = refresh_q + REF_W'(1);
        idx_d     = idx_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = '0;
            idx_d     = idx_q + IDX_W'(1);
        end
        an_d = ~(4'b0001 << idx_d);
        case (idx_d)
            2'd0:    nib_d = cnt1_d[3:0];
            2'd1:    nib_d = cnt1_d[7:4];
            2'd2:    nib_d = cnt2_d[3:0];
            default: nib_d = cnt2_d[7:4];
        endcase
        seg_d = glyph(nib_d) ^ SEG_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z1_q      <= 1'b0;
            z2_q      <= 1'b0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            ovf1_q    <= 1'b0;
            ovf2_q    <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1110;
            seg_q     <= SEG_ZERO;
        end else begin
            z1_q      <= z1;
            z2_q      <= z2;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            ovf1_q    <= ovf1_d;
            ovf2_q    <= ovf2_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
    assign ovf1 = ovf1_q;
    assign ovf2 = ovf2_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_detect_event_counter.sv
// Directed bench for detect_event_counter with a short refresh period (4 cycles/digit).
module tb_detect_event_counter;

    logic       clk = 1'b0;
    logic       rst, z1, z2, clr;
    logic [7:0] cnt1, cnt2;
    logic       ovf1, ovf2;
    logic [6:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    detect_event_counter #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .z1  (z1),
        .z2  (z2),
        .clr (clr),
        .cnt1(cnt1),
        .cnt2(cnt2),
        .ovf1(ovf1),
        .ovf2(ovf2),
        .seg (seg),
        .an  (an)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic a, input logic b);
        z1 = a;
        z2 = b;
        step();
        z1 = 1'b0;
        z2 = 1'b0;
        step();
    endtask

    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    logic [3:0] an_prev;
    bit         found;

    initial begin
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'b1111000, 7'b0100100, 7'b0010010, 7'b1000000};

        rst = 1'b1; z1 = 1'b0; z2 = 1'b0; clr = 1'b0;
        step();
        step();
        chk("rst_cnt1", cnt1, 8'h00);
        chk("rst_cnt2", cnt2, 8'h00);
        chk("rst_ovf1", 8'(ovf1), 8'h00);
        chk("rst_ovf2", 8'(ovf2), 8'h00);
        chk("rst_an", 8'(an), 8'h0E);
        chk("rst_seg", 8'(seg), 8'h40);
        rst = 1'b0;

        // Held level counts exactly once
        z1 = 1'b1;
        step();
        chk("edge_first", cnt1, 8'h01);
        repeat (4) step();
        chk("edge_held", cnt1, 8'h01);
        z1 = 1'b0;
        step();
        chk("edge_release", cnt1, 8'h01);
        for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
        chk("ten_pulses", cnt1, 8'h10);
        chk("ten_ovf1", 8'(ovf1), 8'h00);

        // Wrap of cnt2 with sticky overflow
        for (int i = 1; i <= 100; i++) begin
            pulse(1'b0, 1'b1);
            if (i == 99) begin
                chk("wrap_99", cnt2, 8'h99);
                chk("wrap_99_ovf", 8'(ovf2), 8'h00);
            end
            if (i == 100) begin
                chk("wrap_00", cnt2, 8'h00);
                chk("wrap_00_ovf", 8'(ovf2), 8'h01);
            end
        end
        pulse(1'b0, 1'b1);
        chk("after_wrap", cnt2, 8'h01);
        chk("after_wrap_ovf", 8'(ovf2), 8'h01);
        chk("cnt1_indep", cnt1, 8'h10);
        chk("ovf1_indep", 8'(ovf1), 8'h00);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt2", cnt2, 8'h00);
        chk("clr_ovf2", 8'(ovf2), 8'h00);
        chk("clr_cnt1", cnt1, 8'h00);

        // Simultaneous events, then clear beating an event
        pulse(1'b1, 1'b1);
        chk("simul_cnt1", cnt1, 8'h01);
        chk("simul_cnt2", cnt2, 8'h01);
        z1 = 1'b1;
        clr = 1'b1;
        step();
        chk("clr_wins", cnt1, 8'h00);
        clr = 1'b0;
        step();
        chk("held_through_clr", cnt1, 8'h00);
        z1 = 1'b0;
        step();
        chk("held_through_clr_cnt2", cnt2, 8'h00);

        // Load 27 / 05 for the scan check
        for (int i = 0; i < 27; i++) pulse(1'b1, (i < 5) ? 1'b1 : 1'b0);
        chk("load_cnt1", cnt1, 8'h27);
        chk("load_cnt2", cnt2, 8'h05);

        // Align to the start of digit 0 dwell
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            an_prev = an;
            step();
            if (an_prev == 4'b0111 && an == 4'b1110) found = 1'b1;
        end
        chk("scan_sync", 8'(found), 8'h01);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan_an_%0d", k), 8'(an), 8'(an_exp[k / 4]));
            chk($sformatf("scan_seg_%0d", k), 8'(seg), 8'(seg_exp[k / 4]));
            step();
        end
        chk("scan_return_an", 8'(an), 8'h0E);
        chk("scan_return_seg", 8'(seg), 8'h78);

        // Count change mid-dwell shows on seg at once
        z1 = 1'b1;
        step();
        z1 = 1'b0;
        chk("middwell_cnt1", cnt1, 8'h28);
        chk("middwell_an", 8'(an), 8'h0E);
        chk("middwell_seg", 8'(seg), 8'h00);

        // Reset mid-scan at digit 2
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (an == 4'b1011) found = 1'b1;
        end
        chk("idx2_sync", 8'(found), 8'h01);
        rst = 1'b1;
        z1 = 1'b1;
        step();
        chk("midrst_cnt1", cnt1, 8'h00);
        chk("midrst_cnt2", cnt2, 8'h00);
        chk("midrst_ovf1", 8'(ovf1), 8'h00);
        chk("midrst_ovf2", 8'(ovf2), 8'h00);
        chk("midrst_an", 8'(an), 8'h0E);
        chk("midrst_seg", 8'(seg), 8'h40);
        rst = 1'b0;
        step();
        chk("rst_release_z1", cnt1, 8'h01);
        chk("rst_release_seg", 8'(seg), 8'h79);
        z1 = 1'b0;
        step();
        chk("rst_release_hold", cnt1, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
